// File: rtl/uart_frame_rx.sv
// UART receiver and frame parser for the board's length-prefixed ramp test frames.
// A frame is a length byte N (0..MAX_LENGTH) followed by N payload bytes whose
// value at 1-based position i is i. The receiver oversamples rx, recovers 8N1
// bytes, delimits frames and checks the payload against the ramp.
//
// Ports:
//   clock        system clock
//   reset        asynchronous active-low reset; clears all state and outputs
//   rx           serial input, idle high, asynchronous to clock
//   byte_valid   one-cycle pulse, byte_data holds a newly received good byte
//   byte_data    last received good byte
//   frame_done   one-cycle pulse, a complete frame was received
//   frame_ok     with frame_done: every payload byte matched the ramp (held)
//   frame_length length byte of the last completed frame (held)
//   error        one-cycle pulse on any abort
//   error_code   with error: 1 framing, 2 length too large, 3 inter-byte timeout
module uart_frame_rx #(
  parameter int unsigned CLOCK_FREQUENCY = 48_000_000,
  parameter int unsigned BAUDRATE        = 115_200,
  parameter int unsigned MAX_LENGTH      = 64,
  parameter int unsigned FRAME_TIMEOUT   = 41_600
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_done,
  output logic       frame_ok,
  output logic [7:0] frame_length,
  output logic       error,
  output logic [1:0] error_code
);

  localparam int unsigned DIVIDER = CLOCK_FREQUENCY / BAUDRATE;
  localparam int unsigned HALF    = DIVIDER / 2;
  localparam int unsigned BaudW   = $clog2(DIVIDER);
  localparam int unsigned TimeW   = $clog2(FRAME_TIMEOUT);

  typedef enum logic [1:0] {BitIdle, BitStart, BitData, BitStop} bit_state_e;
  typedef enum logic {ParLength, ParPayload} par_state_e;

  // Synchronizer; flops reset high so a reset does not fake a start edge.
  logic       rx_meta_q, rxs;
  logic [1:0] sync_fill_q;
  logic       armed_q;

  bit_state_e       bit_state_q, bit_state_d;
  logic [BaudW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_good, byte_bad, start_det;

  par_state_e       par_q, par_d;
  logic [7:0]       length_q, length_d;
  logic [7:0]       index_q, index_d;
  logic             match_q, match_d, match_next;
  logic [TimeW-1:0] tcnt_q, tcnt_d;

  logic       byte_valid_d, frame_done_d, frame_ok_d, error_d;
  logic [7:0] byte_data_d, frame_length_d;
  logic [1:0] error_code_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta_q   <= 1'b1;
      rxs         <= 1'b1;
      sync_fill_q <= 2'b00;
      armed_q     <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rxs         <= rx_meta_q;
      sync_fill_q <= {sync_fill_q[0], 1'b1};
      // Only trust rxs once real line samples have reached it: a line held low
      // through reset release must not look like a start bit.
      armed_q     <= armed_q | (sync_fill_q[1] & rxs);
    end
  end

  // Bit recovery
  always_comb begin
    bit_state_d = bit_state_q;
    baud_cnt_d  = baud_cnt_q + 1'b1;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_good   = 1'b0;
    byte_bad    = 1'b0;
    start_det   = 1'b0;
    unique case (bit_state_q)
      BitIdle: begin
        baud_cnt_d = '0;
        if (armed_q && !rxs) begin
          start_det   = 1'b1;
          bit_state_d = BitStart;
        end
      end
      BitStart: begin
        if (baud_cnt_q == BaudW'(HALF - 1)) begin
          baud_cnt_d  = '0;
          bit_cnt_d   = '0;
          bit_state_d = rxs ? BitIdle : BitData;
        end
      end
      BitData: begin
        if (baud_cnt_q == BaudW'(DIVIDER - 1)) begin
          baud_cnt_d = '0;
          shift_d    = {rxs, shift_q[7:1]};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) bit_state_d = BitStop;
        end
      end
      BitStop: begin
        // Back to idle at mid stop bit so a following start edge is not missed.
        if (baud_cnt_q == BaudW'(DIVIDER - 1)) begin
          baud_cnt_d  = '0;
          bit_state_d = BitIdle;
          byte_good   = rxs;
          byte_bad    = !rxs;
        end
      end
      default: bit_state_d = BitIdle;
    endcase
  end

  // Frame parser and output registers
  always_comb begin
    par_d          = par_q;
    length_d       = length_q;
    index_d        = index_q;
    match_d        = match_q;
    tcnt_d         = tcnt_q;
    byte_valid_d   = 1'b0;
    byte_data_d    = byte_data;
    frame_done_d   = 1'b0;
    frame_ok_d     = frame_ok;
    frame_length_d = frame_length;
    error_d        = 1'b0;
    error_code_d   = error_code;
    match_next     = match_q && (shift_q == index_q);

    if (par_q != ParPayload || start_det) begin
      tcnt_d = '0;
    end else if (bit_state_q == BitIdle) begin
      if (tcnt_q == TimeW'(FRAME_TIMEOUT - 1)) begin
        tcnt_d       = '0;
        error_d      = 1'b1;
        error_code_d = 2'd3;
        par_d        = ParLength;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
    end

    if (byte_bad) begin
      error_d      = 1'b1;
      error_code_d = 2'd1;
      par_d        = ParLength;
    end else if (byte_good) begin
      byte_valid_d = 1'b1;
      byte_data_d  = shift_q;
      if (par_q == ParLength) begin
        if (shift_q == 8'd0) begin
          frame_done_d   = 1'b1;
          frame_ok_d     = 1'b1;
          frame_length_d = 8'd0;
        end else if (32'(shift_q) > MAX_LENGTH) begin
          error_d      = 1'b1;
          error_code_d = 2'd2;
        end else begin
          length_d = shift_q;
          index_d  = 8'd1;
          match_d  = 1'b1;
          par_d    = ParPayload;
        end
      end else begin
        match_d = match_next;
        if (index_q == length_q) begin
          frame_done_d   = 1'b1;
          frame_ok_d     = match_next;
          frame_length_d = length_q;
          par_d          = ParLength;
        end else begin
          index_d = index_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bit_state_q  <= BitIdle;
      baud_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= ParLength;
      length_q     <= '0;
      index_q      <= '0;
      match_q      <= 1'b0;
      tcnt_q       <= '0;
      byte_valid   <= 1'b0;
      byte_data    <= '0;
      frame_done   <= 1'b0;
      frame_ok     <= 1'b0;
      frame_length <= '0;
      error        <= 1'b0;
      error_code   <= '0;
    end else begin
      bit_state_q  <= bit_state_d;
      baud_cnt_q   <= baud_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      length_q     <= length_d;
      index_q      <= index_d;
      match_q      <= match_d;
      tcnt_q       <= tcnt_d;
      byte_valid   <= byte_valid_d;
      byte_data    <= byte_data_d;
      frame_done   <= frame_done_d;
      frame_ok     <= frame_ok_d;
      frame_length <= frame_length_d;
      error        <= error_d;
      error_code   <= error_code_d;
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx. A frame-level model turns every byte
// the bench sends into an expected output event; a monitor compares every DUT
// pulse against that queue and checks the held frame outputs each cycle.
// Divider and timeout are scaled down to keep the run short.
module tb_uart_frame_rx;

  localparam int unsigned ClkFreq = 1_843_200;
  localparam int unsigned Baud    = 115_200;
  localparam int unsigned Div     = 16;
  localparam int unsigned Half    = 8;
  localparam int unsigned MaxLen  = 64;
  localparam int unsigned Timeout = 1600;

  logic       clock, reset, rx;
  logic       byte_valid, frame_done, frame_ok, error;
  logic [7:0] byte_data, frame_length;
  logic [1:0] error_code;

  uart_frame_rx #(
    .CLOCK_FREQUENCY(ClkFreq),
    .BAUDRATE       (Baud),
    .MAX_LENGTH     (MaxLen),
    .FRAME_TIMEOUT  (Timeout)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rx          (rx),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .frame_done  (frame_done),
    .frame_ok    (frame_ok),
    .frame_length(frame_length),
    .error       (error),
    .error_code  (error_code)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       bv;
    logic [7:0] data;
    logic       fd;
    logic       fok;
    logic [7:0] flen;
    logic       er;
    logic [1:0] ec;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  // Frame-level model state
  bit  m_in_frame = 1'b0;
  int  m_len = 0;
  int  m_got[$];

  // Monitor observations
  int  cycle = 0;
  int  last_bv_cycle = 0;
  int  n_bv = 0, n_fd = 0, n_er = 0;
  int  last_ec = 0;
  bit  hold_ok = 1'b0;
  int  hold_len = 0;

  function automatic void check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", name, got, want, cycle);
    end
  endfunction

  function automatic void model_byte(input logic [7:0] b, input logic stop_ok);
    ev_t e = '{default: 0};
    if (!stop_ok) begin
      e.er = 1'b1;
      e.ec = 2'd1;
      m_in_frame = 1'b0;
      m_got.delete();
    end else begin
      e.bv = 1'b1;
      e.data = b;
      if (!m_in_frame) begin
        if (b == 8'd0) begin
          e.fd = 1'b1; e.fok = 1'b1; e.flen = 8'd0;
        end else if (int'(b) > MaxLen) begin
          e.er = 1'b1; e.ec = 2'd2;
        end else begin
          m_in_frame = 1'b1;
          m_len = int'(b);
          m_got.delete();
        end
      end else begin
        m_got.push_back(int'(b));
        if (m_got.size() == m_len) begin
          e.fd = 1'b1;
          e.flen = 8'(m_len);
          e.fok = 1'b1;
          foreach (m_got[i]) if (m_got[i] != i + 1) e.fok = 1'b0;
          m_in_frame = 1'b0;
        end
      end
    end
    exp_q.push_back(e);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    model_byte(b, stop_ok);
    rx = 1'b0;
    tick(Div);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(Div);
    end
    rx = stop_ok;
    // A bad stop bit is held just past the sample point, then the line idles.
    tick(stop_ok ? Div : Half + 4);
    rx = 1'b1;
    if (!stop_ok) tick(3 * Div);
  endtask

  task automatic send_frame(input int len, input int bad_pos);
    send_byte(8'(len), 1'b1);
    for (int i = 1; i <= len; i++) send_byte((i == bad_pos) ? 8'hFF : 8'(i), 1'b1);
  endtask

  task automatic idle(input int n);
    if (m_in_frame && n >= int'(Timeout)) begin
      ev_t e = '{default: 0};
      e.er = 1'b1;
      e.ec = 2'd3;
      exp_q.push_back(e);
      m_in_frame = 1'b0;
      m_got.delete();
    end
    rx = 1'b1;
    tick(n);
  endtask

  task automatic monitor();
    ev_t e;
    forever begin
      @(negedge clock);
      cycle++;
      if (!reset) begin
        hold_ok = 1'b0;
        hold_len = 0;
        check("reset_outputs_zero",
              int'({byte_valid, frame_done, frame_ok, error, error_code, byte_data, frame_length}), 0);
      end else begin
        if (frame_done && error) check("done_error_exclusive", 1, 0);
        if (byte_valid || frame_done || error) begin
          if (exp_q.size() == 0) begin
            check("unexpected_event", int'({byte_valid, frame_done, error}), 0);
          end else begin
            e = exp_q.pop_front();
            check("byte_valid", int'(byte_valid), int'(e.bv));
            if (e.bv) check("byte_data", int'(byte_data), int'(e.data));
            check("frame_done", int'(frame_done), int'(e.fd));
            if (e.fd) begin
              check("frame_ok", int'(frame_ok), int'(e.fok));
              check("frame_length", int'(frame_length), int'(e.flen));
              hold_ok = e.fok;
              hold_len = int'(e.flen);
            end
            check("error", int'(error), int'(e.er));
            if (e.er) check("error_code", int'(error_code), int'(e.ec));
          end
          if (error && error_code == 2'd3)
            check("timeout_latency", cycle - last_bv_cycle, int'(Timeout));
          if (byte_valid) begin n_bv++; last_bv_cycle = cycle; end
          if (frame_done) n_fd++;
          if (error) begin n_er++; last_ec = int'(error_code); end
        end
        check("frame_ok_hold", int'(frame_ok), int'(hold_ok));
        check("frame_length_hold", int'(frame_length), hold_len);
      end
    end
  endtask

  initial begin
    int bv0, fd0, er0;
    fork
      monitor();
    join_none

    rx = 1'b1;
    reset = 1'b0;
    tick(3);
    check("rst_byte_valid", int'(byte_valid), 0);
    check("rst_byte_data", int'(byte_data), 0);
    check("rst_frame_ok", int'(frame_ok), 0);
    check("rst_frame_length", int'(frame_length), 0);
    check("rst_error_code", int'(error_code), 0);
    reset = 1'b1;
    tick(5);

    // Full-length good frame
    bv0 = n_bv; fd0 = n_fd; er0 = n_er;
    send_frame(64, 0);
    tick(Div);
    check("t1_byte_count", n_bv - bv0, 65);
    check("t1_frame_count", n_fd - fd0, 1);
    check("t1_error_count", n_er - er0, 0);
    check("t1_frame_ok", int'(frame_ok), 1);
    check("t1_frame_length", int'(frame_length), 64);

    // Corrupted payload byte 10, then a clean frame
    send_frame(64, 10);
    tick(Div);
    check("t2_frame_ok_bad", int'(frame_ok), 0);
    check("t2_frame_length", int'(frame_length), 64);
    send_frame(64, 0);
    tick(Div);
    check("t2_frame_ok_recover", int'(frame_ok), 1);

    // Framing error inside a frame, then a short good frame
    bv0 = n_bv; er0 = n_er;
    send_byte(8'd3, 1'b1);
    send_byte(8'd1, 1'b0);
    check("t3_framing_code", last_ec, 1);
    check("t3_error_count", n_er - er0, 1);
    check("t3_no_bv_bad_byte", n_bv - bv0, 1);
    send_frame(2, 0);
    tick(Div);
    check("t3_frame_ok", int'(frame_ok), 1);
    check("t3_frame_length", int'(frame_length), 2);

    // Oversized length, then an empty frame
    send_byte(8'd200, 1'b1);
    check("t4_length_code", last_ec, 2);
    fd0 = n_fd;
    send_byte(8'd0, 1'b1);
    tick(Div);
    check("t4_empty_done", n_fd - fd0, 1);
    check("t4_frame_ok", int'(frame_ok), 1);
    check("t4_frame_length", int'(frame_length), 0);

    // Inter-byte timeout, then recovery
    send_byte(8'd64, 1'b1);
    for (int i = 1; i <= 3; i++) send_byte(8'(i), 1'b1);
    idle(Timeout + 40);
    check("t5_timeout_code", last_ec, 3);
    send_frame(4, 0);
    tick(Div);
    check("t5_frame_ok", int'(frame_ok), 1);
    check("t5_frame_length", int'(frame_length), 4);

    // Short low glitch is rejected
    bv0 = n_bv; er0 = n_er;
    rx = 1'b0;
    tick(Half - 3);
    rx = 1'b1;
    tick(2 * Div);
    check("t6_glitch_no_byte", n_bv - bv0, 0);
    check("t6_glitch_no_error", n_er - er0, 0);

    // Reset in the middle of payload byte 30, with the line held low past release
    send_byte(8'd64, 1'b1);
    for (int i = 1; i <= 29; i++) send_byte(8'(i), 1'b1);
    check("t7_queue_drained", exp_q.size(), 0);
    rx = 1'b0;
    tick(Div);
    rx = 1'b0;
    tick(3 * Div);
    reset = 1'b0;
    m_in_frame = 1'b0;
    m_got.delete();
    tick(2);
    check("t7_rst_frame_ok", int'(frame_ok), 0);
    check("t7_rst_frame_length", int'(frame_length), 0);
    reset = 1'b1;
    tick(3 * Div);
    rx = 1'b1;
    tick(2 * Div);
    bv0 = n_bv; er0 = n_er;
    check("t7_low_line_no_byte", n_bv - bv0, 0);
    send_frame(5, 0);
    tick(Div);
    check("t7_fresh_frame_ok", int'(frame_ok), 1);
    check("t7_fresh_frame_length", int'(frame_length), 5);
    check("t7_no_spurious_error", n_er - er0, 0);

    tick(Div);
    check("pending_events", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_frame_rx.md
# uart_frame_rx

UART receiver and frame parser that terminates the length-prefixed test frames produced by the board's UART transmitter: a length byte N followed by N payload bytes whose value at position i (1-based) is i. It oversamples `rx`, recovers 8N1 bytes, delimits frames by the length byte and checks each payload against the expected ramp. It sits at the receive pin and feeds the status/LED logic.

## Interface
- CLOCK_FREQUENCY, 48_000_000, clock frequency in Hz
- BAUDRATE, 115_200, line rate; DIVIDER = CLOCK_FREQUENCY/BAUDRATE (integer, 416 by default), HALF = DIVIDER/2
- MAX_LENGTH, 64, largest legal length byte
- FRAME_TIMEOUT, 41_600, idle clocks allowed between bytes inside a frame
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low; all state and outputs clear while low
- rx  in  1  serial input, idle high, asynchronous to `clock`
- byte_valid  out  1  one-cycle pulse: `byte_data` holds a newly received byte
- byte_data  out  8  last received byte
- frame_done  out  1  one-cycle pulse: a complete frame was received
- frame_ok  out  1  valid with `frame_done`: every payload byte matched the ramp
- frame_length  out  8  length byte of the last completed frame
- error  out  1  one-cycle pulse on any abort
- error_code  out  2  valid with `error`: 1 = framing (stop bit 0), 2 = length > MAX_LENGTH, 3 = timeout

## Operation
- Reset values: all pulses 0, `byte_data` 0, `frame_ok` 0, `frame_length` 0, `error_code` 0; bit FSM IDLE, parser LENGTH, all counters 0.
- `rx` passes through a 2-flop synchronizer (flops reset to 1); all logic uses the synchronized value `rxs`.
- Bit FSM: IDLE, START, DATA, STOP.
  - IDLE: on `rxs` = 0, go to START and clear the baud counter.
  - START: at counter HALF-1, sample `rxs`. If 1 (glitch), return to IDLE. If 0, clear the counter and go to DATA.
  - DATA: sample at counter DIVIDER-1 and clear the counter. Bits arrive LSB first into a shift register. After 8 bits, go to STOP.
  - STOP: sample at DIVIDER-1. If 1, the byte is good. If 0, raise a framing error. Go directly to IDLE; no wait for end of stop bit.
- Parser FSM: LENGTH, PAYLOAD.
  - LENGTH, good byte b:
    - b = 0: `frame_done` with `frame_ok` = 1, `frame_length` = 0; stay in LENGTH.
    - b > MAX_LENGTH: error code 2; stay in LENGTH.
    - Otherwise: store the length, set index = 1 and match = 1, go to PAYLOAD.
  - PAYLOAD, good byte: if byte ≠ index, clear match. When index = length: `frame_done`, `frame_ok` = match, `frame_length` = length, return to LENGTH. Otherwise increment index.
- Framing error in either parser state: error code 1; parser returns to LENGTH; the partial frame is discarded.
- Timeout: counts only while the parser is in PAYLOAD and the bit FSM is in IDLE; clears whenever a start is detected. At FRAME_TIMEOUT-1: error code 3, parser to LENGTH.
- `byte_valid` fires for every good byte, length bytes included, and never for framing-error bytes.
- Index and length are 8-bit; MAX_LENGTH ≤ 255 guarantees no wrap.

## Timing
- Synchronizer latency: 2 clocks from `rx` to `rxs`.
- `byte_valid`, `byte_data`, `frame_done`, `frame_ok`, `frame_length`, `error` and `error_code` all update on the clock edge after the stop-bit sample.
- `frame_done` for a frame's last byte is coincident with that byte's `byte_valid`.
- `frame_done` and `error` are never asserted in the same cycle.
- `frame_ok` and `frame_length` hold until the next `frame_done`.
- A start edge is accepted on the first IDLE cycle after STOP. Back-to-back bytes with a single stop bit are received without loss.
- Reset low mid-byte or mid-frame: immediate clear, no pulses. After release, a line held low is not taken as a start until `rxs` has been seen high.

## Test plan
- Send length 64 followed by payload 1..64 at 115200 baud -> 65 `byte_valid` pulses; a single `frame_done` with `frame_ok` = 1, `frame_length` = 64; `error` never asserted.
- Same frame with payload byte 10 sent as 0xFF -> `frame_done` with `frame_ok` = 0, `frame_length` = 64; the next correct frame gives `frame_ok` = 1.
- Send length 3, then byte 1 with stop bit forced 0 -> `error` with code 1 and no `byte_valid` for that byte. Then send 2,1,2 -> `frame_done`, `frame_ok` = 1, `frame_length` = 2.
- Send length byte 200 -> `error` code 2, parser stays in LENGTH. Then 0 -> `frame_done`, `frame_ok` = 1, `frame_length` = 0.
- Send length 64, bytes 1..3, then hold idle for 41_600 clocks -> `error` code 3 on cycle FRAME_TIMEOUT-1 of idle; the next frame is received normally.
- Pull `rx` low for 100 clocks -> no byte and no error. Assert reset during payload byte 30 of a frame -> all outputs 0; a fresh frame after release gives `frame_ok` = 1.
